// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode constants and scoreboard FSM state shared by the issue logic
package rv32_pkg;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_e;
endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: combinational RV32I register-usage decode
// i_instr: instruction; o_rs1/o_rs2/o_rd: register fields; o_use_*: field is
// read/written and nonzero (x0 never matters); o_fence: MISC-MEM opcode
module reg_use_decode
  import rv32_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_use_rs1,
  output logic        o_use_rs2,
  output logic        o_use_rd,
  output logic        o_fence
);
  logic [6:0] op;
  logic       u1, u2, ud;
  logic       unused_bits;
  assign op          = i_instr[6:0];
  assign o_rs1       = i_instr[19:15];
  assign o_rs2       = i_instr[24:20];
  assign o_rd        = i_instr[11:7];
  assign unused_bits = ^{i_instr[31:25], i_instr[14:12]};
  always_comb begin
    u1 = op inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    u2 = op inside {OP_OP, OP_STORE, OP_BRANCH};
    ud = op inside {OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
  end
  assign o_use_rs1 = u1 && |o_rs1;
  assign o_use_rs2 = u2 && |o_rs2;
  assign o_use_rd  = ud && |o_rd;
  assign o_fence   = op == OP_MISC_MEM;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order RAW/WAW issue scoreboard with fence drain and stall watchdog
// i_clk/i_rst (async, active-low); decode: i_id_valid, i_id_instr, i_ex_ready, i_flush;
// writeback: i_wb_valid, i_wb_rd_addr; o_issue/o_stall handshake, o_busy pending
// writes, o_stall_cnt saturating stall count, o_timeout sticky watchdog
module issue_scoreboard
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_id_valid,
  input  logic [31:0]            i_id_instr,
  input  logic                   i_ex_ready,
  input  logic                   i_flush,
  input  logic                   i_wb_valid,
  input  logic [4:0]             i_wb_rd_addr,
  output logic                   o_issue,
  output logic                   o_stall,
  output logic [31:0]            o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic                   o_timeout
);
  localparam int             CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO = CW'(TIMEOUT_CYCLES);
  state_e                 state_q, state_d;
  logic [31:0]            busy_q, busy_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]          con_q, con_d;
  logic                   to_q, to_d;
  logic                   fok_q, fok_d;
  logic [4:0]             rs1, rs2, rd;
  logic                   use_rs1, use_rs2, use_rd, fence;
  logic                   live, hazard;
  reg_use_decode u_dec (
    .i_instr  (i_id_instr),
    .o_rs1    (rs1),
    .o_rs2    (rs2),
    .o_rd     (rd),
    .o_use_rs1(use_rs1),
    .o_use_rs2(use_rs2),
    .o_use_rd (use_rd),
    .o_fence  (fence)
  );
  assign live   = i_id_valid && !i_flush;
  assign hazard = (use_rs1 && busy_q[rs1]) || (use_rs2 && busy_q[rs2]) || (use_rd && busy_q[rd]);
  // fok_q marks a fence that has already drained: it may issue like a normal instruction
  assign o_issue = state_q != DRAIN && live && i_ex_ready && !hazard && (!fence || fok_q);
  assign o_stall = state_q == DRAIN ? !i_flush : live && !o_issue;
  always_comb begin
    state_d = i_flush ? RUN
            : state_q == DRAIN ? (|busy_q ? DRAIN : RUN)
            : (live && fence && !fok_q) ? DRAIN
            : o_stall ? STALL : RUN;
    fok_d = (state_q == DRAIN && !(|busy_q) && !i_flush) || (fok_q && live && !o_issue);
    busy_d = busy_q;
    if (i_wb_valid) busy_d[i_wb_rd_addr] = 1'b0;
    if (o_issue && use_rd) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = (o_stall && !(&cnt_q)) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
    con_d = !o_stall ? '0 : con_q == TO ? con_q : con_q + CW'(1);
    to_d  = to_q || con_d == TO;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= RUN;
      busy_q  <= '0;
      cnt_q   <= '0;
      con_q   <= '0;
      to_q    <= 1'b0;
      fok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      con_q   <= con_d;
      to_q    <= to_d;
      fok_q   <= fok_d;
    end
  end
  assign o_busy      = busy_q;
  assign o_stall_cnt = cnt_q;
  assign o_timeout   = to_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;
  import rv32_pkg::*;
  localparam logic [31:0] FENCE = 32'h0ff0000f;
  logic        clk = 0, rst_n = 0;
  logic        id_valid = 0, ex_ready = 0, flush = 0, wb_valid = 0;
  logic [31:0] instr = 0;
  logic [4:0]  wb_rd = 0;
  logic        o_issue, o_stall, o_timeout;
  logic [31:0] o_busy;
  logic [15:0] o_stall_cnt;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];

  issue_scoreboard #(.TIMEOUT_CYCLES(4), .STALL_CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_id_valid(id_valid), .i_id_instr(instr),
    .i_ex_ready(ex_ready), .i_flush(flush), .i_wb_valid(wb_valid), .i_wb_rd_addr(wb_rd),
    .o_issue(o_issue), .o_stall(o_stall), .o_busy(o_busy),
    .o_stall_cnt(o_stall_cnt), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, OP_OP};
  endfunction
  function automatic logic [31:0] f_addi(logic [4:0] rd, logic [4:0] rs1);
    return {12'd1, rs1, 3'd0, rd, OP_IMM};
  endfunction
  function automatic logic [31:0] f_lui(logic [4:0] rd);
    return {20'h12345, rd, OP_LUI};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                       input logic wv, input logic [4:0] wr);
    id_valid = v; instr = ins; ex_ready = rdy; flush = fl; wb_valid = wv; wb_rd = wr;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  // every issue seen by the DUT must match the oldest instruction expected to issue
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n === 1'b1 && o_issue === 1'b1) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
      chk("issue_instr", instr, e);
    end
  end

  initial begin
    // reset: empty scoreboard, combinational issue still follows inputs
    drive(1, f_add(5'd1, 5'd2, 5'd3), 1, 0, 0, 5'd0);
    neg;
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", 32'(o_stall_cnt), 0);
    chk("rst_to", 32'(o_timeout), 0);
    chk("rst_issue", 32'(o_issue), 1);
    chk("rst_stall", 32'(o_stall), 0);
    tick;
    rst_n = 1;
    // RAW stall on x5 until the cycle after its writeback
    drive(1, f_add(5'd5, 5'd1, 5'd2), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("raw_i1", 32'(o_issue), 1); tick;
    drive(1, f_add(5'd6, 5'd5, 5'd3), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("raw_stall1", 32'(o_stall), 1); chk("raw_noiss1", 32'(o_issue), 0);
    chk("raw_busy1", o_busy, 32'h20); tick;
    drive(1, f_add(5'd6, 5'd5, 5'd3), 1, 0, 1, 5'd5);
    neg; chk("raw_stall2", 32'(o_stall), 1); chk("raw_busy2", o_busy, 32'h20); tick;
    drive(1, f_add(5'd6, 5'd5, 5'd3), 1, 0, 0, 5'd0);
    neg; chk("raw_iss", 32'(o_issue), 1); chk("raw_nostall", 32'(o_stall), 0);
    chk("raw_busy3", o_busy, 0); chk("raw_cnt", 32'(o_stall_cnt), 2); tick;
    drive(0, 0, 1, 0, 1, 5'd6);
    neg; chk("raw_busy4", o_busy, 32'h40); tick;
    // x0 never becomes busy nor causes a hazard
    drive(1, f_lui(5'd0), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("x0_lui", 32'(o_issue), 1); chk("x0_busy0", o_busy, 0); tick;
    drive(1, f_add(5'd1, 5'd0, 5'd0), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("x0_add", 32'(o_issue), 1); chk("x0_busy1", o_busy, 0); tick;
    drive(0, 0, 1, 0, 1, 5'd1);
    neg; chk("x0_busy2", o_busy, 32'h2); tick;
    // set wins over same-cycle clear; clear is not bypassed
    drive(1, f_addi(5'd7, 5'd0), 1, 0, 1, 5'd7); exp_q.push_back(instr);
    neg; chk("sw_iss", 32'(o_issue), 1); tick;
    drive(1, f_addi(5'd8, 5'd7), 1, 0, 1, 5'd7); exp_q.push_back(instr);
    neg; chk("sw_busy", o_busy, 32'h80); chk("nb_stall", 32'(o_stall), 1); tick;
    drive(1, f_addi(5'd8, 5'd7), 1, 0, 0, 5'd0);
    neg; chk("nb_iss", 32'(o_issue), 1); chk("nb_busy", o_busy, 0); tick;
    drive(0, 0, 1, 0, 1, 5'd8);
    neg; chk("nb_busy2", o_busy, 32'h100); tick;
    // fence drains x3,x4 then issues the cycle after busy is empty
    drive(1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("fn_b0", o_busy, 0); tick;
    drive(1, f_addi(5'd4, 5'd0), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("fn_b1", o_busy, 32'h8); tick;
    drive(1, FENCE, 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("fn_b2", o_busy, 32'h18); chk("fn_st0", 32'(o_stall), 1); chk("fn_is0", 32'(o_issue), 0); tick;
    drive(1, FENCE, 1, 0, 1, 5'd3);
    neg; chk("fn_st1", 32'(o_stall), 1); chk("fn_state", 32'(dut.state_q), 32'(DRAIN)); tick;
    drive(1, FENCE, 1, 0, 1, 5'd4);
    neg; chk("fn_b3", o_busy, 32'h10); chk("fn_st2", 32'(o_stall), 1); tick;
    drive(1, FENCE, 1, 0, 0, 5'd0);
    neg; chk("fn_b4", o_busy, 0); chk("fn_st3", 32'(o_stall), 1); chk("fn_is3", 32'(o_issue), 0);
    chk("fn_to0", 32'(o_timeout), 0); tick;
    neg; chk("fn_iss", 32'(o_issue), 1); chk("fn_st4", 32'(o_stall), 0); chk("fn_cnt", 32'(o_stall_cnt), 7); tick;
    drive(0, 0, 1, 0, 0, 5'd0);
    neg; chk("fn_nobusy", o_busy, 0); chk("fn_to1", 32'(o_timeout), 1); tick;
    // watchdog: four consecutive stalls raise a sticky timeout
    rst_n = 0;
    neg; chk("r2_busy", o_busy, 0); chk("r2_to", 32'(o_timeout), 0); chk("r2_cnt", 32'(o_stall_cnt), 0); tick;
    rst_n = 1;
    drive(1, f_addi(5'd1, 5'd0), 1, 0, 0, 5'd0); exp_q.push_back(instr);
    neg; chk("to_i", 32'(o_issue), 1); tick;
    drive(1, f_add(5'd2, 5'd1, 5'd1), 1, 0, 0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      neg; chk("to_st", 32'(o_stall), 1); chk("to_lo", 32'(o_timeout), 0); tick;
    end
    for (int i = 0; i < 2; i++) begin
      neg; chk("to_hi", 32'(o_timeout), 1); tick;
    end
    // flush kills the stalled instruction but keeps the busy vector
    drive(1, f_add(5'd2, 5'd1, 5'd1), 1, 1, 0, 5'd0);
    neg; chk("fl_is", 32'(o_issue), 0); chk("fl_st", 32'(o_stall), 0); chk("fl_busy", o_busy, 32'h2); tick;
    drive(0, 0, 1, 0, 0, 5'd0);
    neg; chk("fl_state", 32'(dut.state_q), 32'(RUN)); chk("fl_to", 32'(o_timeout), 1);
    chk("fl_cnt", 32'(o_stall_cnt), 6); tick;
    // reset mid-drain discards everything
    drive(1, FENCE, 1, 0, 0, 5'd0);
    neg; chk("rd_st", 32'(o_stall), 1); tick;
    neg; chk("rd_drain", 32'(dut.state_q), 32'(DRAIN)); tick;
    drive(0, 0, 1, 0, 0, 5'd0);
    rst_n = 0;
    neg; chk("rd_busy", o_busy, 0); chk("rd_to", 32'(o_timeout), 0);
    chk("rd_state", 32'(dut.state_q), 32'(RUN)); tick;
    rst_n = 1;
    tick;
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the consecutive stall cycles after which o_timeout asserts.
REQ-002 The block SHALL have parameter STALL_CNT_W, default 16, the width of the stall performance counter.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_id_valid  input  1  instruction present in decode.
REQ-006 i_id_instr  input  32  RV32I instruction in decode.
REQ-007 i_ex_ready  input  1  execute stage can accept an instruction this cycle.
REQ-008 i_flush  input  1  kill the decode instruction this cycle (branch redirect).
REQ-009 i_wb_valid  input  1  writeback retiring a register write this cycle.
REQ-010 i_wb_rd_addr  input  5  destination of the retiring write.
REQ-011 o_issue  output  1  decode instruction moves to execute this cycle.
REQ-012 o_stall  output  1  decode instruction valid but held.
REQ-013 o_busy  output  32  per-register pending-write vector.
REQ-014 o_stall_cnt  output  STALL_CNT_W  saturating count of stall cycles.
REQ-015 o_timeout  output  1  sticky; stall exceeded TIMEOUT_CYCLES.

Function
REQ-016 Register usage SHALL be decoded from opcode [6:0]: OP 0110011 rs1,rs2,rd; OP-IMM 0010011 rs1,rd; LOAD 0000011 rs1,rd; STORE 0100011 rs1,rs2; BRANCH 1100011 rs1,rs2; JALR 1100111 rs1,rd; JAL 1101111 rd; LUI 0110111, AUIPC 0010111 rd; MISC-MEM 0001111 fence; others none.
REQ-017 rs1=[19:15], rs2=[24:20], rd=[11:7]; register 0 SHALL never be busy, never cause a hazard, never be set.
REQ-018 Hazard SHALL be: any used source busy (RAW) or used rd busy (WAW), evaluated on current o_busy.
REQ-019 FSM states RUN, STALL, DRAIN; reset state RUN.
REQ-020 In RUN or STALL: o_issue = i_id_valid & ~i_flush & i_ex_ready & ~hazard & not a fence; o_issue is combinational.
REQ-021 o_stall = i_id_valid & ~i_flush & ~o_issue.
REQ-022 RUN->STALL when o_stall; STALL->RUN when no stall; any state->RUN on i_flush.
REQ-023 A valid, unflushed fence SHALL enter DRAIN; in DRAIN o_issue=0, o_stall=1; DRAIN->RUN the cycle after o_busy==0, issuing the fence then if i_ex_ready (issuing a fence sets no busy bit).
REQ-024 On o_issue with used rd!=0, busy[rd] SHALL set at the next edge.
REQ-025 On i_wb_valid with rd!=0, busy[i_wb_rd_addr] SHALL clear at the next edge; clear takes effect next cycle (no same-cycle bypass).
REQ-026 Simultaneous set and clear of the same register: set SHALL win.
REQ-027 o_stall_cnt SHALL increment each o_stall cycle and saturate at all-ones.
REQ-028 A consecutive-stall counter SHALL reset on any non-stall cycle; o_timeout SHALL set when it reaches TIMEOUT_CYCLES and hold until reset.
REQ-029 i_flush SHALL not alter o_busy; in-flight instructions still write back.

Reset
REQ-030 While i_rst low: state RUN, o_busy=0, o_stall_cnt=0, consecutive counter 0, o_timeout=0; o_issue/o_stall follow REQ-020/021 with empty busy vector.
REQ-031 Reset mid-DRAIN or mid-STALL SHALL discard all pending state with no residual busy bits.

Structure
REQ-032 Opcode constants and the FSM state enum SHALL live in a shared package (rv32_pkg).
REQ-033 Register-usage decode SHALL be one combinational sub-module, reg_use_decode (instr -> rs1/rs2/rd addresses and use flags, fence flag).

Verification
REQ-034 add x5,x1,x2 issued, then add x6,x5,x3 -> stall until cycle after wb rd=5; o_stall_cnt counts stall cycles exactly.
REQ-035 lui x0 then add x1,x0,x0 -> no stall, o_busy stays 0.
REQ-036 Issue addi x7 while wb retires x7 same cycle -> busy[7]=1 next cycle.
REQ-037 x3,x4 busy, fence arrives -> DRAIN, o_stall=1 until both retired; fence issues cycle after o_busy==0.
REQ-038 Hold RAW stall with no writeback, TIMEOUT_CYCLES=4 -> o_timeout rises after 4th stall cycle, stays high; i_rst low clears it and o_busy.
REQ-039 Stall on RAW with i_flush=1 -> o_issue=0, o_stall=0, state RUN, o_busy unchanged.
